// File: rtl/mips_mem_pkg.sv
// Shared types for the unified memory port arbiter.
// Owner and state encodings plus counter widths.
package mips_mem_pkg;

   typedef enum logic [1:0] {
      OWN_NONE,
      OWN_IF,
      OWN_DM
   } owner_t;

   typedef enum logic {
      IDLE,
      RD_WAIT
   } arb_state_t;

   localparam int MAX_LATENCY = 8;
   localparam int LAT_W       = $clog2(MAX_LATENCY + 1);
   localparam int STARVE_W    = 4;

endpackage

// File: rtl/mem_port_arbiter_lat_cnt.sv
// Read-latency down counter for the memory port arbiter.
// Load wins over decrement; holds at zero.
module mem_latency_counter
   import mips_mem_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [LAT_W-1:0] load_val,
   input  logic             dec,
   output logic             zero
);

   logic [LAT_W-1:0] count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (dec && count != '0) begin
         count <= count - LAT_W'(1);
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between fetch and load/store.
// DM has priority; a starvation counter forces IF through.
module mem_port_arbiter
   import mips_mem_pkg::*;
#(
   parameter int ADDR_WIDTH   = 32,
   parameter int DATA_WIDTH   = 32,
   parameter int MEM_LATENCY  = 1,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  if_req_i,
   input  logic [ADDR_WIDTH-1:0] if_addr_i,
   output logic                  if_gnt_o,
   output logic                  if_rvalid_o,
   output logic [DATA_WIDTH-1:0] if_rdata_o,
   input  logic                  dm_req_i,
   input  logic                  dm_we_i,
   input  logic [ADDR_WIDTH-1:0] dm_addr_i,
   input  logic [DATA_WIDTH-1:0] dm_wdata_i,
   output logic                  dm_gnt_o,
   output logic                  dm_rvalid_o,
   output logic [DATA_WIDTH-1:0] dm_rdata_o,
   output logic                  mem_en_o,
   output logic                  mem_we_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic [DATA_WIDTH-1:0] mem_wdata_o,
   input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

   localparam logic [LAT_W-1:0] LAT_LOAD =
      LAT_W'(MEM_LATENCY - 1);
   localparam logic [STARVE_W-1:0] STARVE_MAX =
      STARVE_W'(STARVE_LIMIT);

   arb_state_t          state;
   owner_t              owner;
   logic [STARVE_W-1:0] starve_cnt;
   logic                lat_zero;
   logic                rd_done;
   logic                free;
   logic                force_if;
   logic                dm_win;
   logic                if_win;
   logic                rd_grant;

   // The rvalid cycle doubles as a grant slot for back-to-back reads.
   assign rd_done  = (state == RD_WAIT) && lat_zero;
   assign free     = (state == IDLE) || rd_done;
   assign force_if = (starve_cnt == STARVE_MAX);

   assign dm_win = !reset && free && dm_req_i &&
                   !(if_req_i && force_if);
   assign if_win = !reset && free && if_req_i && !dm_win;

   assign rd_grant = if_win || (dm_win && !dm_we_i);

   assign if_gnt_o = if_win;
   assign dm_gnt_o = dm_win;

   assign if_rvalid_o = rd_done && (owner == OWN_IF);
   assign dm_rvalid_o = rd_done && (owner == OWN_DM);
   assign if_rdata_o  = mem_rdata_i;
   assign dm_rdata_o  = mem_rdata_i;

   assign mem_wdata_o = dm_wdata_i;

   always_comb begin
      mem_en_o   = 1'b0;
      mem_we_o   = 1'b0;
      mem_addr_o = if_addr_i;
      unique case (1'b1)
         dm_win: begin
            mem_en_o   = 1'b1;
            mem_we_o   = dm_we_i;
            mem_addr_o = dm_addr_i;
         end
         if_win: begin
            mem_en_o   = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         owner      <= OWN_NONE;
         starve_cnt <= '0;
      end else begin
         if (rd_grant) begin
            state <= RD_WAIT;
            owner <= if_win ? OWN_IF : OWN_DM;
         end else if (rd_done) begin
            state <= IDLE;
            owner <= OWN_NONE;
         end
         if (!if_req_i || if_win) begin
            starve_cnt <= '0;
         end else if (dm_win && starve_cnt != STARVE_MAX) begin
            starve_cnt <= starve_cnt + STARVE_W'(1);
         end
      end
   end

   mem_latency_counter u_lat (
      .clk      (clk),
      .reset    (reset),
      .load     (rd_grant),
      .load_val (LAT_LOAD),
      .dec      (state == RD_WAIT),
      .zero     (lat_zero)
   );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (latency 1 and 3),
// directed scenarios plus random traffic against a timestamp model.
module tb_mem_port_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst       [2];
   logic        if_req    [2];
   logic [31:0] if_addr   [2];
   logic        if_gnt    [2];
   logic        if_rvalid [2];
   logic [31:0] if_rdata  [2];
   logic        dm_req    [2];
   logic        dm_we     [2];
   logic [31:0] dm_addr   [2];
   logic [31:0] dm_wdata  [2];
   logic        dm_gnt    [2];
   logic        dm_rvalid [2];
   logic [31:0] dm_rdata  [2];
   logic        mem_en    [2];
   logic        mem_we    [2];
   logic [31:0] mem_addr  [2];
   logic [31:0] mem_wdata [2];
   logic [31:0] mem_rdata [2];

   int checks = 0;
   int errors = 0;

   mem_port_arbiter #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32),
      .MEM_LATENCY(1), .STARVE_LIMIT(2)
   ) dut0 (
      .clk(clk), .reset(rst[0]),
      .if_req_i(if_req[0]), .if_addr_i(if_addr[0]),
      .if_gnt_o(if_gnt[0]), .if_rvalid_o(if_rvalid[0]),
      .if_rdata_o(if_rdata[0]),
      .dm_req_i(dm_req[0]), .dm_we_i(dm_we[0]),
      .dm_addr_i(dm_addr[0]), .dm_wdata_i(dm_wdata[0]),
      .dm_gnt_o(dm_gnt[0]), .dm_rvalid_o(dm_rvalid[0]),
      .dm_rdata_o(dm_rdata[0]),
      .mem_en_o(mem_en[0]), .mem_we_o(mem_we[0]),
      .mem_addr_o(mem_addr[0]), .mem_wdata_o(mem_wdata[0]),
      .mem_rdata_i(mem_rdata[0])
   );

   mem_port_arbiter #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32),
      .MEM_LATENCY(3), .STARVE_LIMIT(3)
   ) dut1 (
      .clk(clk), .reset(rst[1]),
      .if_req_i(if_req[1]), .if_addr_i(if_addr[1]),
      .if_gnt_o(if_gnt[1]), .if_rvalid_o(if_rvalid[1]),
      .if_rdata_o(if_rdata[1]),
      .dm_req_i(dm_req[1]), .dm_we_i(dm_we[1]),
      .dm_addr_i(dm_addr[1]), .dm_wdata_i(dm_wdata[1]),
      .dm_gnt_o(dm_gnt[1]), .dm_rvalid_o(dm_rvalid[1]),
      .dm_rdata_o(dm_rdata[1]),
      .mem_en_o(mem_en[1]), .mem_we_o(mem_we[1]),
      .mem_addr_o(mem_addr[1]), .mem_wdata_o(mem_wdata[1]),
      .mem_rdata_i(mem_rdata[1])
   );

   // Memory macro model: word array plus a read-data delay line.
   logic [31:0] mem [2][256];
   bit          wr  [2][256];
   logic [31:0] dly [2][8];

   function automatic logic [31:0] mem_word(int k, int i);
      if (wr[k][i]) return mem[k][i];
      return 32'hA5A5_0000 ^ (32'(i) * 32'h0001_0101) ^ 32'(k);
   endfunction

   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         for (int j = 7; j > 0; j--) dly[k][j] <= dly[k][j-1];
         if (mem_en[k] && !mem_we[k])
            dly[k][0] <= mem_word(k, int'(mem_addr[k][9:2]));
         else
            dly[k][0] <= 32'hBAD0_BAD0;
         if (mem_en[k] && mem_we[k]) begin
            mem[k][mem_addr[k][9:2]] <= mem_wdata[k];
            wr[k][mem_addr[k][9:2]]  <= 1'b1;
         end
      end
   end

   assign mem_rdata[0] = dly[0][0];
   assign mem_rdata[1] = dly[1][2];

   // Reference model: one outstanding read tracked by its due cycle.
   bit          m_busy   [2];
   int          m_due    [2];
   int          m_owner  [2];
   int          m_starve [2];
   logic [31:0] m_data   [2];
   int          cyc      [2];
   int          e_win    [2];
   bit          e_rv     [2];
   bit          e_if_rv  [2];
   bit          e_dm_rv  [2];

   function automatic int lat_of(int k);
      return (k == 0) ? 1 : 3;
   endfunction

   function automatic int lim_of(int k);
      return (k == 0) ? 2 : 3;
   endfunction

   task automatic model_eval(int k);
      bit free;
      bit frc;
      e_rv[k] = m_busy[k] && (cyc[k] == m_due[k]);
      free = !m_busy[k] || e_rv[k];
      frc = (m_starve[k] == lim_of(k));
      e_win[k] = 0;
      if (!rst[k] && free) begin
         if (dm_req[k] && !(if_req[k] && frc)) e_win[k] = 2;
         else if (if_req[k]) e_win[k] = 1;
      end
      e_if_rv[k] = !rst[k] && e_rv[k] && (m_owner[k] == 1);
      e_dm_rv[k] = !rst[k] && e_rv[k] && (m_owner[k] == 2);
   endtask

   task automatic model_commit(int k);
      int idx;
      if (rst[k]) begin
         m_busy[k] = 0;
         m_starve[k] = 0;
      end else begin
         if (e_rv[k]) m_busy[k] = 0;
         if (e_win[k] == 1 || (e_win[k] == 2 && !dm_we[k])) begin
            idx = (e_win[k] == 1) ? int'(if_addr[k][9:2])
                                  : int'(dm_addr[k][9:2]);
            m_busy[k] = 1;
            m_due[k] = cyc[k] + lat_of(k);
            m_owner[k] = e_win[k];
            m_data[k] = mem_word(k, idx);
         end
         if (!if_req[k] || e_win[k] == 1) m_starve[k] = 0;
         else if (e_win[k] == 2 && m_starve[k] < lim_of(k))
            m_starve[k] = m_starve[k] + 1;
      end
      cyc[k] = cyc[k] + 1;
   endtask

   task automatic tick();
      for (int k = 0; k < 2; k++) begin
         model_eval(k);
         model_commit(k);
      end
      @(negedge clk);
   endtask

   task automatic idle_inputs(int k);
      if_req[k] = 1'b0;
      dm_req[k] = 1'b0;
      dm_we[k]  = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         if_req[k] = 1'b1;
         dm_req[k] = 1'b1;
         dm_we[k]  = 1'b1;
      end
      #1;
      for (int k = 0; k < 2; k++) begin
         checks++;
         if ({if_gnt[k], dm_gnt[k], mem_en[k], mem_we[k],
              if_rvalid[k], dm_rvalid[k]} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs dut%0d got %b%b%b%b%b%b want 000000",
                     k, if_gnt[k], dm_gnt[k], mem_en[k], mem_we[k],
                     if_rvalid[k], dm_rvalid[k]);
         end
      end
      tick();
      for (int k = 0; k < 2; k++) begin
         idle_inputs(k);
         rst[k] = 1'b0;
      end
      tick();
   endtask

   task automatic test_if_read();
      logic [31:0] exp;
      exp = mem_word(0, 0);
      if_req[0] = 1'b1;
      if_addr[0] = 32'h0040_0000;
      #1;
      checks++;
      if ({if_gnt[0], mem_en[0], mem_we[0], dm_gnt[0]} !== 4'b1100) begin
         errors++;
         $display("FAIL t1_grant got %b%b%b%b want 1100",
                  if_gnt[0], mem_en[0], mem_we[0], dm_gnt[0]);
      end
      checks++;
      if (mem_addr[0] !== 32'h0040_0000) begin
         errors++;
         $display("FAIL t1_addr got %h want 00400000", mem_addr[0]);
      end
      tick();
      if_req[0] = 1'b0;
      #1;
      checks++;
      if ({if_rvalid[0], dm_rvalid[0]} !== 2'b10) begin
         errors++;
         $display("FAIL t1_rvalid got %b%b want 10",
                  if_rvalid[0], dm_rvalid[0]);
      end
      checks++;
      if (if_rdata[0] !== exp) begin
         errors++;
         $display("FAIL t1_rdata got %h want %h", if_rdata[0], exp);
      end
      tick();
      #1;
      checks++;
      if (if_rvalid[0] !== 1'b0) begin
         errors++;
         $display("FAIL t1_single_rvalid got %b want 0", if_rvalid[0]);
      end
      tick();
   endtask

   task automatic test_priority();
      logic [31:0] ei;
      logic [31:0] ed;
      ei = mem_word(0, 1);
      ed = mem_word(0, 2);
      if_req[0] = 1'b1;
      if_addr[0] = 32'h0040_0004;
      dm_req[0] = 1'b1;
      dm_we[0] = 1'b0;
      dm_addr[0] = 32'h1001_0008;
      #1;
      checks++;
      if ({dm_gnt[0], if_gnt[0]} !== 2'b10) begin
         errors++;
         $display("FAIL t2_dm_first got %b%b want 10", dm_gnt[0], if_gnt[0]);
      end
      tick();
      dm_req[0] = 1'b0;
      #1;
      checks++;
      if ({dm_rvalid[0], if_gnt[0]} !== 2'b11) begin
         errors++;
         $display("FAIL t2_dm_rv_if_gnt got %b%b want 11",
                  dm_rvalid[0], if_gnt[0]);
      end
      checks++;
      if (dm_rdata[0] !== ed) begin
         errors++;
         $display("FAIL t2_dm_rdata got %h want %h", dm_rdata[0], ed);
      end
      tick();
      if_req[0] = 1'b0;
      #1;
      checks++;
      if ({if_rvalid[0], dm_rvalid[0]} !== 2'b10) begin
         errors++;
         $display("FAIL t2_if_rv got %b%b want 10", if_rvalid[0], dm_rvalid[0]);
      end
      checks++;
      if (if_rdata[0] !== ei) begin
         errors++;
         $display("FAIL t2_if_rdata got %h want %h", if_rdata[0], ei);
      end
      tick();
   endtask

   task automatic test_store();
      if_req[0] = 1'b1;
      if_addr[0] = 32'h1001_0004;
      dm_req[0] = 1'b1;
      dm_we[0] = 1'b1;
      dm_addr[0] = 32'h1001_0004;
      dm_wdata[0] = 32'hDEAD_BEEF;
      #1;
      checks++;
      if ({dm_gnt[0], if_gnt[0], mem_en[0], mem_we[0]} !== 4'b1011) begin
         errors++;
         $display("FAIL t3_store_gnt got %b%b%b%b want 1011",
                  dm_gnt[0], if_gnt[0], mem_en[0], mem_we[0]);
      end
      checks++;
      if ({mem_addr[0], mem_wdata[0]} !== 64'h1001_0004_DEAD_BEEF) begin
         errors++;
         $display("FAIL t3_store_bus got %h %h want 10010004 deadbeef",
                  mem_addr[0], mem_wdata[0]);
      end
      tick();
      dm_req[0] = 1'b0;
      dm_we[0] = 1'b0;
      #1;
      checks++;
      if ({dm_rvalid[0], if_gnt[0], mem_we[0]} !== 3'b010) begin
         errors++;
         $display("FAIL t3_after_store got %b%b%b want 010",
                  dm_rvalid[0], if_gnt[0], mem_we[0]);
      end
      tick();
      if_req[0] = 1'b0;
      #1;
      checks++;
      if (if_rvalid[0] !== 1'b1 || if_rdata[0] !== 32'hDEAD_BEEF) begin
         errors++;
         $display("FAIL t3_readback got %b %h want 1 deadbeef",
                  if_rvalid[0], if_rdata[0]);
      end
      tick();
   endtask

   task automatic test_starvation();
      int want [6] = '{2, 2, 1, 2, 2, 1};
      int got;
      if_req[0] = 1'b1;
      if_addr[0] = 32'h0040_0010;
      dm_req[0] = 1'b1;
      dm_we[0] = 1'b1;
      for (int i = 0; i < 6; i++) begin
         dm_addr[0] = $urandom() & 32'hFFFF_FFFC;
         dm_wdata[0] = $urandom();
         #1;
         got = dm_gnt[0] ? 2 : (if_gnt[0] ? 1 : 0);
         checks++;
         if (got !== want[i]) begin
            errors++;
            $display("FAIL t4_order slot %0d got %0d want %0d", i, got, want[i]);
         end
         tick();
      end
      idle_inputs(0);
      #1;
      checks++;
      if (if_rvalid[0] !== 1'b1) begin
         errors++;
         $display("FAIL t4_tail_rvalid got %b want 1", if_rvalid[0]);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      int want_g [7] = '{2, 0, 0, 1, 0, 0, 0};
      int want_r [7] = '{0, 0, 0, 2, 0, 0, 1};
      logic [31:0] ed;
      logic [31:0] ei;
      int got_g;
      int got_r;
      ed = mem_word(1, 8);
      ei = mem_word(1, 16);
      for (int i = 0; i < 7; i++) begin
         dm_req[1] = (i == 0);
         dm_we[1] = 1'b0;
         dm_addr[1] = 32'h1001_0020;
         if_req[1] = (i >= 1 && i <= 3);
         if_addr[1] = 32'h0040_0040;
         #1;
         got_g = dm_gnt[1] ? 2 : (if_gnt[1] ? 1 : 0);
         got_r = dm_rvalid[1] ? 2 : (if_rvalid[1] ? 1 : 0);
         checks++;
         if (got_g !== want_g[i] || mem_en[1] !== (want_g[i] != 0)) begin
            errors++;
            $display("FAIL t5_gnt cycle %0d got %0d en %b want %0d",
                     i, got_g, mem_en[1], want_g[i]);
         end
         checks++;
         if (got_r !== want_r[i]) begin
            errors++;
            $display("FAIL t5_rvalid cycle %0d got %0d want %0d",
                     i, got_r, want_r[i]);
         end
         if (want_r[i] == 2) begin
            checks++;
            if (dm_rdata[1] !== ed) begin
               errors++;
               $display("FAIL t5_dm_rdata got %h want %h", dm_rdata[1], ed);
            end
         end
         if (want_r[i] == 1) begin
            checks++;
            if (if_rdata[1] !== ei) begin
               errors++;
               $display("FAIL t5_if_rdata got %h want %h", if_rdata[1], ei);
            end
         end
         tick();
      end
      idle_inputs(1);
      tick();
   endtask

   task automatic test_reset_mid_read();
      logic [31:0] ei;
      ei = mem_word(1, 33);
      if_req[1] = 1'b1;
      if_addr[1] = 32'h0040_0080;
      #1;
      checks++;
      if (if_gnt[1] !== 1'b1) begin
         errors++;
         $display("FAIL t6_first_gnt got %b want 1", if_gnt[1]);
      end
      tick();
      rst[1] = 1'b1;
      for (int i = 0; i < 2; i++) begin
         #1;
         checks++;
         if ({if_gnt[1], dm_gnt[1], mem_en[1], mem_we[1],
              if_rvalid[1], dm_rvalid[1]} !== 6'b0) begin
            errors++;
            $display("FAIL t6_in_reset cycle %0d got %b%b%b%b%b%b want 000000",
                     i, if_gnt[1], dm_gnt[1], mem_en[1], mem_we[1],
                     if_rvalid[1], dm_rvalid[1]);
         end
         tick();
      end
      rst[1] = 1'b0;
      idle_inputs(1);
      for (int i = 0; i < 5; i++) begin
         #1;
         checks++;
         if ({if_rvalid[1], dm_rvalid[1], mem_en[1]} !== 3'b000) begin
            errors++;
            $display("FAIL t6_no_rvalid cycle %0d got %b%b%b want 000",
                     i, if_rvalid[1], dm_rvalid[1], mem_en[1]);
         end
         tick();
      end
      if_req[1] = 1'b1;
      if_addr[1] = 32'h0040_0084;
      #1;
      checks++;
      if (if_gnt[1] !== 1'b1) begin
         errors++;
         $display("FAIL t6_regrant got %b want 1", if_gnt[1]);
      end
      tick();
      if_req[1] = 1'b0;
      tick();
      tick();
      #1;
      checks++;
      if (if_rvalid[1] !== 1'b1 || if_rdata[1] !== ei) begin
         errors++;
         $display("FAIL t6_regrant_rv got %b %h want 1 %h",
                  if_rvalid[1], if_rdata[1], ei);
      end
      tick();
   endtask

   task automatic test_random(int k, int n);
      bit if_last;
      bit dm_last;
      logic [31:0] ea;
      if_last = 0;
      dm_last = 0;
      for (int i = 0; i < n; i++) begin
         if (m_busy[k] && m_owner[k] == 1 && cyc[k] != m_due[k]) begin
            if_req[k] = 1'b0;
         end else if (!if_req[k] || if_last) begin
            if_req[k] = ($urandom_range(0, 9) < 6);
            if_addr[k] = $urandom() & 32'hFFFF_FFFC;
         end else if ($urandom_range(0, 9) == 0) begin
            if_req[k] = 1'b0;
         end
         if (m_busy[k] && m_owner[k] == 2 && cyc[k] != m_due[k]) begin
            dm_req[k] = 1'b0;
         end else if (!dm_req[k] || dm_last) begin
            dm_req[k] = ($urandom_range(0, 9) < 5);
            dm_we[k] = $urandom_range(0, 1);
            dm_addr[k] = $urandom() & 32'hFFFF_FFFC;
            dm_wdata[k] = $urandom();
         end else if ($urandom_range(0, 9) == 0) begin
            dm_req[k] = 1'b0;
         end
         #1;
         model_eval(k);
         checks++;
         if ({if_gnt[k], dm_gnt[k], mem_en[k]} !==
             {e_win[k] == 1, e_win[k] == 2, e_win[k] != 0}) begin
            errors++;
            $display("FAIL rand_gnt dut%0d cyc %0d got if%b dm%b en%b want winner %0d",
                     k, i, if_gnt[k], dm_gnt[k], mem_en[k], e_win[k]);
         end
         checks++;
         if (mem_we[k] !== (e_win[k] == 2 && dm_we[k])) begin
            errors++;
            $display("FAIL rand_we dut%0d cyc %0d got %b", k, i, mem_we[k]);
         end
         if (e_win[k] != 0) begin
            ea = (e_win[k] == 2) ? dm_addr[k] : if_addr[k];
            checks++;
            if (mem_addr[k] !== ea) begin
               errors++;
               $display("FAIL rand_addr dut%0d cyc %0d got %h want %h",
                        k, i, mem_addr[k], ea);
            end
         end
         checks++;
         if ({if_rvalid[k], dm_rvalid[k]} !== {e_if_rv[k], e_dm_rv[k]}) begin
            errors++;
            $display("FAIL rand_rvalid dut%0d cyc %0d got %b%b want %b%b",
                     k, i, if_rvalid[k], dm_rvalid[k], e_if_rv[k], e_dm_rv[k]);
         end
         if (e_if_rv[k]) begin
            checks++;
            if (if_rdata[k] !== m_data[k]) begin
               errors++;
               $display("FAIL rand_if_rdata dut%0d cyc %0d got %h want %h",
                        k, i, if_rdata[k], m_data[k]);
            end
         end
         if (e_dm_rv[k]) begin
            checks++;
            if (dm_rdata[k] !== m_data[k]) begin
               errors++;
               $display("FAIL rand_dm_rdata dut%0d cyc %0d got %h want %h",
                        k, i, dm_rdata[k], m_data[k]);
            end
         end
         if_last = (e_win[k] == 1);
         dm_last = (e_win[k] == 2);
         tick();
      end
      idle_inputs(k);
      for (int i = 0; i < 5; i++) tick();
   endtask

   initial begin
      for (int k = 0; k < 2; k++) begin
         rst[k] = 1'b1;
         if_req[k] = 1'b0;
         if_addr[k] = '0;
         dm_req[k] = 1'b0;
         dm_we[k] = 1'b0;
         dm_addr[k] = '0;
         dm_wdata[k] = '0;
         m_busy[k] = 0;
         m_due[k] = 0;
         m_owner[k] = 0;
         m_starve[k] = 0;
         m_data[k] = '0;
         cyc[k] = 0;
      end
      test_reset();
      test_if_read();
      test_priority();
      test_store();
      test_starvation();
      test_back_to_back();
      test_reset_mid_read();
      test_random(0, 400);
      test_random(1, 400);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
